// File: rtl/mem_arb_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter.
package mem_arb_pkg;

    // Arbiter state: idle, or port granted to one requester.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } arb_state_e;

    // Requester identifiers.
    typedef enum logic {
        REQ_IF  = 1'b0,
        REQ_MEM = 1'b1
    } req_id_e;

    // Word accesses only: any set low address bit is an error.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/mem_arb_timeout.sv
// Loadable down-counter bounding how long a grant may wait for an ack.
module mem_arb_timeout #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Reload on grant, count down while waiting, hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the IF and MEM pipeline stages.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ready_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ready_o,
    output logic              port_req_o,
    output logic              port_we_o,
    output logic [ADDR_W-1:0] port_addr_o,
    output logic [DATA_W-1:0] port_wdata_o,
    input  logic [DATA_W-1:0] port_rdata_i,
    input  logic              port_ack_i,
    output logic              stall_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    arb_state_e        state, state_next;
    req_id_e           grant_id;
    logic              do_grant;
    logic              if_pend, mem_pend, if_bad, mem_bad;
    logic              req_next, we_next, err_next;
    logic [ADDR_W-1:0] addr_next;
    logic [DATA_W-1:0] wdata_next, if_rdata_next, mem_rdata_next;
    logic              if_ready_next, mem_ready_next;
    logic              tmr_load, tmr_dec, tmr_expired;

    // A request whose ready pulse is showing is already served; its req is stale.
    assign if_pend  = if_req_i & ~if_ready_o;
    assign mem_pend = mem_req_i & ~mem_ready_o;
    assign if_bad   = is_misaligned(if_addr_i[1:0]);
    assign mem_bad  = is_misaligned(mem_addr_i[1:0]);
    assign stall_o  = if_pend | mem_pend;

    mem_arb_timeout #(
        .WIDTH (TMR_W)
    ) u_timeout (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .load     (tmr_load),
        .load_val (TMR_W'(TIMEOUT - 1)),
        .dec      (tmr_dec),
        .expired  (tmr_expired)
    );

    // Next-state, grant selection and completion handling.
    always_comb begin
        state_next     = state;
        req_next       = port_req_o;
        we_next        = port_we_o;
        addr_next      = port_addr_o;
        wdata_next     = port_wdata_o;
        if_rdata_next  = if_rdata_o;
        mem_rdata_next = mem_rdata_o;
        if_ready_next  = 1'b0;
        mem_ready_next = 1'b0;
        err_next       = err_o;
        tmr_load       = 1'b0;
        tmr_dec        = 1'b0;
        do_grant       = 1'b0;
        grant_id       = REQ_MEM;

        case (state)
            IDLE: begin
                // MEM holds the older instruction, so it wins a tie.
                if (mem_pend) begin
                    if (mem_bad) begin
                        mem_ready_next = 1'b1;
                        mem_rdata_next = '0;
                        err_next       = 1'b1;
                    end else begin
                        do_grant = 1'b1;
                        grant_id = REQ_MEM;
                    end
                end else if (if_pend) begin
                    if (if_bad) begin
                        if_ready_next = 1'b1;
                        if_rdata_next = '0;
                        err_next      = 1'b1;
                    end else begin
                        do_grant = 1'b1;
                        grant_id = REQ_IF;
                    end
                end
            end
            GNT_IF, GNT_MEM: begin
                if (port_ack_i || tmr_expired) begin
                    if (state == GNT_MEM) begin
                        mem_ready_next = 1'b1;
                        mem_rdata_next = port_ack_i ? port_rdata_i : '0;
                    end else begin
                        if_ready_next = 1'b1;
                        if_rdata_next = port_ack_i ? port_rdata_i : '0;
                    end
                    if (!port_ack_i) begin
                        err_next = 1'b1;
                    end
                    state_next = IDLE;
                    req_next   = 1'b0;
                    // Hand over to the other requester only; a misaligned one
                    // is resolved from IDLE on the following edge.
                    if (port_ack_i) begin
                        if (state == GNT_MEM && if_pend && !if_bad) begin
                            do_grant = 1'b1;
                            grant_id = REQ_IF;
                        end else if (state == GNT_IF && mem_pend && !mem_bad) begin
                            do_grant = 1'b1;
                            grant_id = REQ_MEM;
                        end
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                req_next   = 1'b0;
            end
        endcase

        if (do_grant) begin
            tmr_load = 1'b1;
            req_next = 1'b1;
            if (grant_id == REQ_MEM) begin
                state_next = GNT_MEM;
                we_next    = mem_we_i;
                addr_next  = mem_addr_i;
                wdata_next = mem_wdata_i;
            end else begin
                state_next = GNT_IF;
                we_next    = 1'b0;
                addr_next  = if_addr_i;
                wdata_next = '0;
            end
        end
    end

    // State and registered outputs; reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= IDLE;
            port_req_o   <= 1'b0;
            port_we_o    <= 1'b0;
            port_addr_o  <= '0;
            port_wdata_o <= '0;
            if_rdata_o   <= '0;
            mem_rdata_o  <= '0;
            if_ready_o   <= 1'b0;
            mem_ready_o  <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            state        <= state_next;
            port_req_o   <= req_next;
            port_we_o    <= we_next;
            port_addr_o  <= addr_next;
            port_wdata_o <= wdata_next;
            if_rdata_o   <= if_rdata_next;
            mem_rdata_o  <= mem_rdata_next;
            if_ready_o   <= if_ready_next;
            mem_ready_o  <= mem_ready_next;
            err_o        <= err_next;
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model plus directed vectors.
module tb_mem_port_arbiter;

    localparam int TMO     = 16;
    localparam int CNT_MAX = 15;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [31:0] port_rdata = '0;
    logic        port_ack = 1'b0;

    logic [31:0] if_rdata_o, mem_rdata_o, port_addr_o, port_wdata_o;
    logic        if_ready_o, mem_ready_o, port_req_o, port_we_o, stall_o, err_o;
    logic [3:0]  stall_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    mem_port_arbiter #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (TMO),
        .CNT_W   (4)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .if_req_i     (if_req),
        .if_addr_i    (if_addr),
        .if_rdata_o   (if_rdata_o),
        .if_ready_o   (if_ready_o),
        .mem_req_i    (mem_req),
        .mem_we_i     (mem_we),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_rdata_o  (mem_rdata_o),
        .mem_ready_o  (mem_ready_o),
        .port_req_o   (port_req_o),
        .port_we_o    (port_we_o),
        .port_addr_o  (port_addr_o),
        .port_wdata_o (port_wdata_o),
        .port_rdata_i (port_rdata),
        .port_ack_i   (port_ack),
        .stall_o      (stall_o),
        .err_o        (err_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- behavioural model ----------------
    // owner: 0 = port idle, 1 = IF holds the port, 2 = MEM holds the port.
    int          m_owner = 0;
    int          m_age = 0;
    int          m_cnt = 0;
    logic        m_req = 0, m_we = 0, m_if_ready = 0, m_mem_ready = 0, m_err = 0;
    logic        m_mem_known = 1;
    logic [31:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_mem_rdata = '0;

    function automatic bit aligned_of(input int who);
        return (who == 1) ? (if_addr[1:0] == 2'b00) : (mem_addr[1:0] == 2'b00);
    endfunction

    always @(posedge clk or negedge rst_i) begin : model
        bit          if_p, mem_p, rdy_if, rdy_mem;
        int          pick, other;
        logic [31:0] data;
        if (!rst_i) begin
            m_owner = 0; m_age = 0; m_cnt = 0;
            m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_if_ready = 0; m_mem_ready = 0; m_if_rdata = '0; m_mem_rdata = '0;
            m_err = 0; m_mem_known = 1;
        end else begin
            if_p  = if_req && !m_if_ready;
            mem_p = mem_req && !m_mem_ready;
            if ((if_p || mem_p) && m_cnt < CNT_MAX) m_cnt++;
            rdy_if = 0; rdy_mem = 0; pick = 0;
            if (m_owner != 0) begin
                m_age++;
                if (port_ack || m_age >= TMO) begin
                    data = port_ack ? port_rdata : 32'h0;
                    if (!port_ack) m_err = 1;
                    if (m_owner == 1) begin
                        rdy_if = 1; m_if_rdata = data;
                    end else begin
                        rdy_mem = 1; m_mem_rdata = data;
                        m_mem_known = !(port_ack && m_we);
                    end
                    other = (m_owner == 1) ? 2 : 1;
                    if (port_ack && ((other == 2) ? mem_p : if_p) && aligned_of(other))
                        pick = other;
                    m_owner = 0;
                    m_req = 0;
                end
            end else begin
                if (mem_p) pick = 2;
                else if (if_p) pick = 1;
                if (pick != 0 && !aligned_of(pick)) begin
                    m_err = 1;
                    if (pick == 1) begin
                        rdy_if = 1; m_if_rdata = '0;
                    end else begin
                        rdy_mem = 1; m_mem_rdata = '0; m_mem_known = 1;
                    end
                    pick = 0;
                end
            end
            if (pick != 0) begin
                m_owner = pick;
                m_age   = 0;
                m_req   = 1;
                m_we    = (pick == 2) ? mem_we : 1'b0;
                m_addr  = (pick == 2) ? mem_addr : if_addr;
                m_wdata = (pick == 2) ? mem_wdata : 32'h0;
            end
            m_if_ready  = rdy_if;
            m_mem_ready = rdy_mem;
        end
    end

    // Compare DUT against model every cycle, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            check("stall", 32'(stall_o), 32'((if_req && !m_if_ready) || (mem_req && !m_mem_ready)));
            check("port_req", 32'(port_req_o), 32'(m_req));
            if (m_req) begin
                check("port_addr", port_addr_o, m_addr);
                check("port_we", 32'(port_we_o), 32'(m_we));
                if (m_we) check("port_wdata", port_wdata_o, m_wdata);
            end
            check("if_ready", 32'(if_ready_o), 32'(m_if_ready));
            check("mem_ready", 32'(mem_ready_o), 32'(m_mem_ready));
            check("if_rdata", if_rdata_o, m_if_rdata);
            if (m_mem_known) check("mem_rdata", mem_rdata_o, m_mem_rdata);
            check("err", 32'(err_o), 32'(m_err));
            check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        int last, n_ev, first;
        #1 rst_i = 1'b0;
        #1;
        check("rst_port_req", 32'(port_req_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(stall_cnt_o), 32'd0);
        check("rst_ready", 32'({if_ready_o, mem_ready_o}), 32'd0);
        step();
        #2 rst_i = 1'b1;
        started = 1;
        step();

        // IF load at 0x10, ack on the third edge after the grant.
        if_req = 1; if_addr = 32'h10;
        step();
        check("ifld_req", 32'(port_req_o), 32'd1);
        check("ifld_addr", port_addr_o, 32'h10);
        check("ifld_we", 32'(port_we_o), 32'd0);
        step();
        step();
        port_ack = 1; port_rdata = 32'hDEADBEEF;
        step();
        check("ifld_ready", 32'(if_ready_o), 32'd1);
        check("ifld_rdata", if_rdata_o, 32'hDEADBEEF);
        check("ifld_req_drop", 32'(port_req_o), 32'd0);
        port_ack = 0;
        step();
        check("ifld_pulse", 32'(if_ready_o), 32'd0);
        check("ifld_no_regrant", 32'(port_req_o), 32'd0);
        if_req = 0;
        step();

        // Simultaneous MEM store and IF fetch, ack every edge.
        mem_req = 1; mem_we = 1; mem_addr = 32'h4; mem_wdata = 32'h5;
        if_req = 1; if_addr = 32'h20;
        port_ack = 1; port_rdata = 32'h1111_2222;
        step();
        check("both_req", 32'(port_req_o), 32'd1);
        check("both_we", 32'(port_we_o), 32'd1);
        check("both_addr", port_addr_o, 32'h4);
        check("both_wdata", port_wdata_o, 32'h5);
        port_rdata = 32'h3333_4444;
        step();
        check("both_mem_ready", 32'(mem_ready_o), 32'd1);
        check("both_if_grant", port_addr_o, 32'h20);
        check("both_b2b_req", 32'(port_req_o), 32'd1);
        check("both_if_wait", 32'(if_ready_o), 32'd0);
        step();
        check("both_if_ready", 32'(if_ready_o), 32'd1);
        check("both_if_rdata", if_rdata_o, 32'h3333_4444);
        check("both_mem_once", 32'(mem_ready_o), 32'd0);
        check("both_idle", 32'(port_req_o), 32'd0);
        mem_req = 0; mem_we = 0; if_req = 0; port_ack = 0;
        step();

        // Continuous requests from both sides with ack every edge.
        mem_req = 1; mem_addr = 32'h100; if_req = 1; if_addr = 32'h200; port_ack = 1;
        last = 0; n_ev = 0; first = 0;
        for (int i = 0; i < 12; i++) begin
            port_rdata = 32'hC000_0000 + i;
            step();
            if (mem_ready_o || if_ready_o) begin
                int cur;
                cur = mem_ready_o ? 1 : 2;
                if (last != 0) check("alt_order", 32'(cur != last), 32'd1);
                else first = cur;
                last = cur;
                n_ev++;
            end
        end
        check("alt_first_mem", 32'(first), 32'd1);
        check("alt_count", 32'(n_ev), 32'd8);
        mem_req = 0; if_req = 0; port_ack = 0;
        step();

        // MEM load with no ack: abort after TMO waiting edges.
        mem_req = 1; mem_we = 0; mem_addr = 32'h40;
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        check("tmo_still_waiting", 32'(port_req_o), 32'd1);
        step();
        check("tmo_req_drop", 32'(port_req_o), 32'd0);
        check("tmo_ready", 32'(mem_ready_o), 32'd1);
        check("tmo_rdata", mem_rdata_o, 32'd0);
        check("tmo_err", 32'(err_o), 32'd1);
        mem_req = 0;
        step();
        check("tmo_err_sticky", 32'(err_o), 32'd1);
        if_req = 1; if_addr = 32'h30;
        step();
        check("tmo_next_addr", port_addr_o, 32'h30);
        port_ack = 1; port_rdata = 32'h5A5A_5A5A;
        step();
        check("tmo_next_ready", 32'(if_ready_o), 32'd1);
        check("tmo_next_rdata", if_rdata_o, 32'h5A5A_5A5A);
        check("cnt_saturated", 32'(stall_cnt_o), 32'd15);
        if_req = 0; port_ack = 0;
        step();

        // Reset while MEM holds the port.
        mem_req = 1; mem_we = 1; mem_addr = 32'h80; mem_wdata = 32'h77;
        step();
        check("rstmid_granted", 32'(port_req_o), 32'd1);
        #1 rst_i = 1'b0;
        #1;
        check("rstmid_req", 32'(port_req_o), 32'd0);
        check("rstmid_we", 32'(port_we_o), 32'd0);
        check("rstmid_addr", port_addr_o, 32'd0);
        check("rstmid_err", 32'(err_o), 32'd0);
        check("rstmid_cnt", 32'(stall_cnt_o), 32'd0);
        mem_req = 0; mem_we = 0;
        #1 rst_i = 1'b1;
        step();
        step();
        check("rstmid_no_ready", 32'(mem_ready_o), 32'd0);

        // Normal load, then a misaligned one.
        mem_req = 1; mem_addr = 32'h8; port_ack = 1; port_rdata = 32'h1234;
        step();
        step();
        check("ld_rdata", mem_rdata_o, 32'h1234);
        mem_req = 0; port_ack = 0;
        step();
        mem_req = 1; mem_addr = 32'h6;
        step();
        check("mis_no_port", 32'(port_req_o), 32'd0);
        check("mis_ready", 32'(mem_ready_o), 32'd1);
        check("mis_rdata", mem_rdata_o, 32'd0);
        check("mis_err", 32'(err_o), 32'd1);
        mem_req = 0;
        step();
        check("mis_pulse", 32'(mem_ready_o), 32'd0);

        // Long stall: counter must stop at all-ones.
        if_req = 1; if_addr = 32'h44;
        for (int i = 0; i < TMO + 1; i++) step();
        check("sat_if_tmo", 32'(if_ready_o), 32'd1);
        check("sat_cnt", 32'(stall_cnt_o), 32'd15);
        if_req = 0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
